// File: rtl/ws_psum_collector_pkg.sv
// Shared systolic-array definitions: default geometry and the psum row type.
package ws_psum_collector_pkg;

    localparam int DEF_COLS       = 8;
    localparam int DEF_ROWS       = 8;
    localparam int DEF_PSUM_WIDTH = 19;   // 8b x 8b product plus 3 accumulation bits
    localparam int DEF_FIFO_DEPTH = 4;

    // One signed partial sum and one full row of them (column c in element c).
    typedef logic signed [DEF_PSUM_WIDTH-1:0] psum_t;
    typedef psum_t [DEF_COLS-1:0]              psum_row_t;

endpackage

// File: rtl/ws_row_fifo.sv
// Synchronous row FIFO with a registered head: out_data_o/out_last_o always show
// the oldest entry, and hold their last value once the FIFO drains.
module ws_row_fifo #(
    parameter int WIDTH = 152,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             push_last_i,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    // Each entry stores {last, data}.
    logic [WIDTH:0]  mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [AW:0]     remain;
    logic [WIDTH:0]  head_q, head_d;
    logic            pop;
    logic            push;

    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == DEPTH_C);
    // Flush wins over both ports; a full FIFO still accepts when the head leaves.
    assign pop          = !empty_o && pop_ready_i && !clr_i;
    assign push_ready_o = !clr_i && (!full_o || pop);
    assign push         = push_valid_i && push_ready_o;
    assign out_data_o   = head_q[WIDTH-1:0];
    assign out_last_o   = head_q[WIDTH];

    // Next pointers, occupancy and head; a push into an otherwise empty FIFO bypasses to the head.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        remain   = count_q - (AW + 1)'(pop);
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = remain + (AW + 1)'(push);
            if (count_d != '0) begin
                head_d = (remain == '0) ? {push_last_i, push_data_i} : mem_q[rd_ptr_d];
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Row storage; contents are only ever read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
        end
    end

endmodule

// File: rtl/ws_psum_collector.sv
// Collects skewed bottom-row psums from a weight-stationary array, deskews them
// into whole rows, tags the last row of each tile and queues rows for the consumer.
module ws_psum_collector
    import ws_psum_collector_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       clr_i,
    input  logic [COLS*PSUM_WIDTH-1:0] psum_i,
    input  logic [COLS-1:0]            psum_valid_i,
    output logic [COLS*PSUM_WIDTH-1:0] out_data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       out_last_o,
    output logic                       overflow_o,
    output logic                       skew_err_o
);

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [COLS*PSUM_WIDTH-1:0] aligned_data;
    logic [COLS-1:0]            aligned_valid;
    logic                       all_valid;
    logic                       any_valid;
    logic                       row_pop;
    logic                       row_accept;
    logic                       row_last;
    logic                       fifo_push_ready;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CNT_W-1:0]           row_cnt_q, row_cnt_d;
    logic                       overflow_q, overflow_d;
    logic                       skew_err_q, skew_err_d;

    // Column c arrives c cycles after column 0, so it waits COLS-1-c cycles to line up.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        localparam int DLY = COLS - 1 - gi;
        if (DLY == 0) begin : g_direct
            assign aligned_data[gi*PSUM_WIDTH +: PSUM_WIDTH] = psum_i[gi*PSUM_WIDTH +: PSUM_WIDTH];
            assign aligned_valid[gi]                         = psum_valid_i[gi];
        end else begin : g_delay
            logic [PSUM_WIDTH-1:0] data_q [DLY];
            logic [DLY-1:0]        valid_q;

            // Shift data and valid together; flush and reset clear the whole line.
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    for (int i = 0; i < DLY; i++) begin
                        data_q[i] <= '0;
                    end
                    valid_q <= '0;
                end else if (clr_i) begin
                    for (int i = 0; i < DLY; i++) begin
                        data_q[i] <= '0;
                    end
                    valid_q <= '0;
                end else begin
                    data_q[0]  <= psum_i[gi*PSUM_WIDTH +: PSUM_WIDTH];
                    valid_q[0] <= psum_valid_i[gi];
                    for (int i = 1; i < DLY; i++) begin
                        data_q[i]  <= data_q[i-1];
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            assign aligned_data[gi*PSUM_WIDTH +: PSUM_WIDTH] = data_q[DLY-1];
            assign aligned_valid[gi]                         = valid_q[DLY-1];
        end
    end

    assign all_valid  = &aligned_valid;
    assign any_valid  = |aligned_valid;
    assign row_pop    = out_valid_o && out_ready_i;
    assign row_accept = all_valid && fifo_push_ready;
    assign row_last   = (row_cnt_q == CNT_W'(ROWS - 1));

    ws_row_fifo #(
        .WIDTH (COLS * PSUM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .nrst         (nrst),
        .clr_i        (clr_i),
        .push_valid_i (all_valid),
        .push_ready_o (fifo_push_ready),
        .push_data_i  (aligned_data),
        .push_last_i  (row_last),
        .pop_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    assign out_valid_o = !fifo_empty;

    // Row position within the tile and the sticky error flags; only accepted rows advance the count.
    always_comb begin
        row_cnt_d  = row_cnt_q;
        overflow_d = overflow_q;
        skew_err_d = skew_err_q;
        if (clr_i) begin
            row_cnt_d  = '0;
            overflow_d = 1'b0;
            skew_err_d = 1'b0;
        end else begin
            if (row_accept) begin
                row_cnt_d = row_last ? '0 : row_cnt_q + CNT_W'(1);
            end
            if (all_valid && fifo_full && !row_pop) begin
                overflow_d = 1'b1;
            end
            if (any_valid && !all_valid) begin
                skew_err_d = 1'b1;
            end
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            row_cnt_q  <= row_cnt_d;
            overflow_q <= overflow_d;
            skew_err_q <= skew_err_d;
        end
    end

    assign overflow_o = overflow_q;
    assign skew_err_o = skew_err_q;

endmodule
